// File: rtl/descram_pkg.sv
// descram_pkg: shared state encoding and sizing helpers for the parallel descrambler
package descram_pkg;
  typedef enum logic [1:0] {ST_PRIME, ST_HUNT, ST_LOCKED} state_t;
  function automatic int prime_words(input int w, input int tap_b);
    return (tap_b + w - 1) / w;
  endfunction
  function automatic int cnt_width(input int lock_cnt, input int unlock_cnt);
    return $clog2((lock_cnt > unlock_cnt ? lock_cnt : unlock_cnt) + 1);
  endfunction
endpackage

// File: rtl/descram_par_if.sv
// descram_par_if: scrambled-word input, descrambled-word output and lock status bundle
interface descram_par_if #(parameter int W = 4);
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         resync;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         locked;
  logic         hunting;
  modport master (output in_valid, in_data, resync, input out_valid, out_data, locked, hunting);
  modport slave  (input in_valid, in_data, resync, output out_valid, out_data, locked, hunting);
endinterface

// File: rtl/descram_core.sv
// descram_core: unrolled self-synchronous recurrence, one word of line bits per evaluation
module descram_core #(
  parameter int W     = 4,
  parameter int TAP_A = 2,
  parameter int TAP_B = 3
) (
  input  logic [TAP_B-1:0] hist_i,
  input  logic [W-1:0]     data_i,
  output logic [W-1:0]     out_o,
  output logic [TAP_B-1:0] hist_o
);
  // Line order runs from the MSB of cat downwards, so bit k sees its taps at k+TAP_A and k+TAP_B.
  logic [TAP_B+W-1:0] cat;
  assign cat = {hist_i, data_i};
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign out_o[i] = cat[i] ^ cat[i+TAP_A] ^ cat[i+TAP_B];
  end
  assign hist_o = cat[TAP_B-1:0];
endmodule

// File: rtl/descram_par.sv
// descram_par: parallel descrambler with priming, idle-based lock hunting and loss-of-lock detection
module descram_par import descram_pkg::*; #(
  parameter int W          = 4,
  parameter int TAP_A      = 2,
  parameter int TAP_B      = 3,
  parameter int LOCK_CNT   = 8,
  parameter int UNLOCK_CNT = 4
) (
  input logic         clk,
  input logic         rst,
  descram_par_if.slave bus
);
  localparam int P  = prime_words(W, TAP_B);
  localparam int PW = $clog2(P + 1);
  localparam int CW = cnt_width(LOCK_CNT, UNLOCK_CNT);
  state_t           state_q, state_d;
  logic [TAP_B-1:0] hist_q, hist_d, next_hist;
  logic [W-1:0]     out_data_q, out_data_d, core_out;
  logic             out_valid_q, out_valid_d, acc, out_zero;
  logic [PW-1:0]    prime_q, prime_d;
  logic [CW-1:0]    zero_q, zero_d, bad_q, bad_d;
  assign acc      = bus.in_valid & ~bus.resync;
  assign out_zero = out_data_q == '0;
  descram_core #(.W(W), .TAP_A(TAP_A), .TAP_B(TAP_B)) u_core (
    .hist_i (hist_q),
    .data_i (bus.in_data),
    .out_o  (core_out),
    .hist_o (next_hist)
  );
  // Lock tracking judges registered output words, so lock changes trail the deciding word by a cycle.
  always_comb begin
    state_d     = state_q;
    hist_d      = acc ? next_hist : hist_q;
    prime_d     = prime_q;
    zero_d      = zero_q;
    bad_d       = bad_q;
    out_valid_d = acc && (state_q != ST_PRIME);
    out_data_d  = out_valid_d ? core_out : out_data_q;
    if (bus.resync) begin
      state_d = ST_PRIME;
      hist_d  = '0;
      prime_d = '0;
      zero_d  = '0;
      bad_d   = '0;
    end else if (state_q == ST_PRIME) begin
      if (acc) begin
        prime_d = prime_q == PW'(P - 1) ? '0 : prime_q + PW'(1);
        state_d = prime_q == PW'(P - 1) ? ST_HUNT : ST_PRIME;
      end
    end else if (out_valid_q && state_q == ST_HUNT) begin
      zero_d = !out_zero ? '0 : zero_q == CW'(LOCK_CNT) ? zero_q : zero_q + CW'(1);
      if (zero_d == CW'(LOCK_CNT)) begin
        state_d = ST_LOCKED;
        zero_d  = '0;
        bad_d   = '0;
      end
    end else if (out_valid_q) begin
      bad_d = out_zero ? '0 : bad_q == CW'(UNLOCK_CNT) ? bad_q : bad_q + CW'(1);
      if (bad_d == CW'(UNLOCK_CNT)) begin
        state_d = ST_HUNT;
        zero_d  = '0;
        bad_d   = '0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_PRIME;
      hist_q      <= '0;
      prime_q     <= '0;
      zero_q      <= '0;
      bad_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      hist_q      <= hist_d;
      prime_q     <= prime_d;
      zero_q      <= zero_d;
      bad_q       <= bad_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.locked    = state_q == ST_LOCKED;
  assign bus.hunting   = state_q == ST_HUNT;
endmodule

// File: tb/tb_descram_par.sv
// tb_descram_par: serial transmit scrambler feeds the descrambler; a scoreboard expects the plaintext back
module tb_descram_par;
  localparam int W = 4, TA = 2, TB = 3, LC = 8, UC = 4;
  localparam int P = (TB + W - 1) / W;
  typedef struct { logic [W-1:0] data; int stamp; } exp_t;
  logic clk = 1'b0, rst = 1'b1;
  int cyc = 0, checks = 0, errors = 0, prime_left = P;
  exp_t exp_q[$];
  bit tx_bits[$];
  descram_par_if #(.W(W)) bus ();
  descram_par #(.W(W), .TAP_A(TA), .TAP_B(TB), .LOCK_CNT(LC), .UNLOCK_CNT(UC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  function automatic bit tx_tap(input int k);
    return tx_bits.size() >= k ? tx_bits[tx_bits.size() - k] : 1'b0;
  endfunction
  // Serial scrambler s[n] = d[n] ^ s[n-TA] ^ s[n-TB]; the receiver should return d once primed.
  task automatic word(input logic [W-1:0] p, input bit v = 1'b1, input bit rs = 1'b0);
    logic [W-1:0] s;
    @(negedge clk);
    s = W'($urandom);
    if (v) begin
      for (int j = W - 1; j >= 0; j--) begin
        s[j] = p[j] ^ tx_tap(TA) ^ tx_tap(TB);
        tx_bits.push_back(s[j]);
      end
    end
    if (rs) prime_left = P;
    else if (v && prime_left > 0) prime_left--;
    else if (v) exp_q.push_back('{p, cyc});
    bus.in_valid = v;
    bus.in_data  = s;
    bus.resync   = rs;
  endtask
  task automatic do_rst();
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.resync   = 1'b0;
    prime_left   = P;
    @(negedge clk);
    rst = 1'b0;
  endtask
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_out_valid", 1, 0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_data", bus.out_data, e.data);
        chk("latency", cyc, e.stamp + 1);
      end
    end
  end
  initial begin
    logic [31:0] cafe;
    bit vp[4];
    cafe = 32'hCAFEBABE;
    vp = '{1, 0, 0, 1};
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.resync   = 1'b0;
    do_rst();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_locked", bus.locked, 0);
    chk("rst_hunting", bus.hunting, 0);
    word(4'h0);
    for (int i = 7; i >= 0; i--) word(cafe[i*4 +: 4]);
    do_rst();
    for (int i = 1; i <= 10; i++) begin
      word(4'h0);
      if (i == 2) chk("t1_hunting", bus.hunting, 1);
      if (i == 10) chk("t1_locked_early", bus.locked, 0);
    end
    word(4'h0, 1'b0);
    chk("t1_locked", bus.locked, 1);
    for (int i = 1; i <= 8; i++) begin
      word(i == 4 ? 4'h0 : W'(i));
      if (i == 5 || i == 8) chk("t3_still_locked", bus.locked, 1);
    end
    word(4'h0, 1'b0);
    chk("t3_locked_last", bus.locked, 1);
    word(4'h0, 1'b0);
    chk("t3_unlocked", bus.locked, 0);
    chk("t3_hunting", bus.hunting, 1);
    for (int i = 0; i < 10; i++) word(4'h0);
    chk("t4_locked", bus.locked, 1);
    for (int i = 0; i < 4; i++) begin
      word(4'h0, vp[i]);
      if (i > 0) chk("t4_out_valid", bus.out_valid, 32'(vp[i-1]));
    end
    word(4'h0, 1'b0);
    chk("t4_out_valid_last", bus.out_valid, 1);
    chk("t4_locked", bus.locked, 1);
    word(4'h7, 1'b1, 1'b1);
    word(4'h0);
    chk("t5_locked", bus.locked, 0);
    chk("t5_hunting", bus.hunting, 0);
    chk("t5_out_valid", bus.out_valid, 0);
    word(4'h5);
    chk("t5_prime_no_valid", bus.out_valid, 0);
    chk("t5_hunting_after", bus.hunting, 1);
    for (int i = 0; i < 80; i++) begin
      int r;
      r = $urandom_range(0, 19);
      if (i == 40) do_rst();
      else word(W'($urandom), r >= 4, i == 20 || r == 0);
    end
    word(4'h0, 1'b0);
    word(4'h0, 1'b0);
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
